spi_mem_arbiter: RTL and testbench

SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

---
 rtl/spi_mem_pkg.sv | 44 ++++
 rtl/spi_shifter.sv | 64 ++++++
 rtl/spi_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared types, SPI opcodes and access-size encoding for the SPI memory arbiter.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    CMD  = 3'd2,
    ADDR = 3'd3,
    DATA = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [7:0] SPI_READ  = 8'h03;
  localparam logic [7:0] SPI_WRITE = 8'h02;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned LEN_W = 6;

  // Bits on the wire for an access size; size 3 behaves as a word.
  function automatic logic [LEN_W-1:0] size_bits(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bits = LEN_W'(8);
      SZ_HALF: size_bits = LEN_W'(16);
      default: size_bits = LEN_W'(32);
    endcase
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    bswap32 = {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Received stream holds byte 0 in its most significant received byte.
  function automatic logic [31:0] rx_order(input logic [31:0] rx, input logic [1:0] size);
    case (size)
      SZ_BYTE: rx_order = {24'h0, rx[7:0]};
      SZ_HALF: rx_order = {16'h0, rx[7:0], rx[15:8]};
      default: rx_order = bswap32(rx);
    endcase
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 bit engine: sclk = clk/2, MSB-first shift out of a left-aligned
// word, miso captured at the end of each sclk-high phase.
module spi_shifter
  import spi_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [31:0]      i_load,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_miso,
  output logic             o_sclk,
  output logic             o_mosi,
  output logic             o_last_c,
  output logic [31:0]      o_rx_next_c
);

  logic             r_active;
  logic             r_sclk;
  logic             r_mosi;
  logic [31:0]      r_sr;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_rx;

  assign o_sclk      = r_sclk;
  assign o_mosi      = r_mosi;
  assign o_last_c    = r_active & r_sclk & (r_cnt == LEN_W'(1));
  assign o_rx_next_c = {r_rx[30:0], i_miso};

  // A start overrides the final high phase so phases chain with no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_rx     <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_sclk   <= 1'b0;
      r_mosi   <= i_load[31];
      r_sr     <= {i_load[30:0], 1'b0};
      r_cnt    <= i_len;
      r_rx     <= '0;
    end else if (r_active) begin
      if (!r_sclk) begin
        r_sclk <= 1'b1;
      end else begin
        r_sclk <= 1'b0;
        r_rx   <= o_rx_next_c;
        r_sr   <= {r_sr[30:0], 1'b0};
        r_cnt  <= r_cnt - LEN_W'(1);
        if (r_cnt == LEN_W'(1)) begin
          r_active <= 1'b0;
          r_mosi   <= 1'b0;
        end else begin
          r_mosi <= r_sr[31];
        end
      end
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Two-master (fetch/data) arbiter onto one SPI bus with flash and RAM selects.
// Define SPI_RAM_EN to serve the RAM region; otherwise RAM accesses error out.
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W:0]   d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_flash_n,
  output logic              cs_ram_n
);

  state_t            r_state, w_state_next;
  logic              r_gnt_d, w_gnt_d_next;
  logic              r_ram, w_ram_next;
  logic              r_last_d;
  logic              r_we;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_cs_flash_n, r_cs_ram_n;
  logic              r_if_ack, r_d_ack, r_d_err;
  logic [31:0]       r_if_rdata, r_d_rdata;

  logic              w_latch, w_err_next, w_reject, w_busy_next, w_done_d;
  logic              w_sh_start, w_sh_last;
  logic [31:0]       w_sh_load, w_rx_next, w_addr_load;
  logic [LEN_W-1:0]  w_sh_len;

  // Accesses that complete without touching the bus, with an error.
`ifdef SPI_RAM_EN
  assign w_reject = !d_addr[ADDR_W] && d_we;
`else
  assign w_reject = d_addr[ADDR_W] || d_we;
`endif

  assign w_addr_load = 32'(r_addr) << (32 - ADDR_W);
  assign w_busy_next = (w_state_next == SEL) || (w_state_next == CMD) ||
                       (w_state_next == ADDR) || (w_state_next == DATA);
  assign w_done_d    = (w_state_next == DONE) && w_gnt_d_next;

  spi_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_sh_start),
    .i_load      (w_sh_load),
    .i_len       (w_sh_len),
    .i_miso      (miso),
    .o_sclk      (sclk),
    .o_mosi      (mosi),
    .o_last_c    (w_sh_last),
    .o_rx_next_c (w_rx_next)
  );

  always_comb begin
    w_state_next = r_state;
    w_gnt_d_next = r_gnt_d;
    w_ram_next   = r_ram;
    w_err_next   = 1'b0;
    w_latch      = 1'b0;
    w_sh_start   = 1'b0;
    w_sh_load    = '0;
    w_sh_len     = '0;
    case (r_state)
      IDLE: begin
        // Data has priority unless it won last time and fetch is waiting.
        if (d_req && !(r_last_d && if_req)) begin
          w_latch      = 1'b1;
          w_gnt_d_next = 1'b1;
          w_ram_next   = d_addr[ADDR_W];
          w_err_next   = w_reject;
          w_state_next = w_reject ? DONE : SEL;
        end else if (if_req) begin
          w_latch      = 1'b1;
          w_gnt_d_next = 1'b0;
          w_ram_next   = 1'b0;
          w_state_next = SEL;
        end
      end
      SEL: begin
        w_state_next = CMD;
        w_sh_start   = 1'b1;
        w_sh_load    = {(r_gnt_d && r_we) ? SPI_WRITE : SPI_READ, 24'h0};
        w_sh_len     = LEN_W'(8);
      end
      CMD: begin
        if (w_sh_last) begin
          w_state_next = ADDR;
          w_sh_start   = 1'b1;
          w_sh_load    = w_addr_load;
          w_sh_len     = LEN_W'(ADDR_W);
        end
      end
      ADDR: begin
        if (w_sh_last) begin
          w_state_next = DATA;
          w_sh_start   = 1'b1;
          w_sh_load    = (r_gnt_d && r_we) ? bswap32(r_wdata) : 32'h0;
          w_sh_len     = size_bits(r_size);
        end
      end
      DATA: begin
        if (w_sh_last) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_gnt_d      <= 1'b0;
      r_ram        <= 1'b0;
      r_last_d     <= 1'b0;
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cs_flash_n <= 1'b1;
      r_cs_ram_n   <= 1'b1;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_d_err      <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_gnt_d      <= w_gnt_d_next;
      r_ram        <= w_ram_next;
      r_cs_flash_n <= !(w_busy_next && !w_ram_next);
`ifdef SPI_RAM_EN
      r_cs_ram_n   <= !(w_busy_next && w_ram_next);
`else
      r_cs_ram_n   <= 1'b1;
`endif
      r_if_ack     <= (w_state_next == DONE) && !w_gnt_d_next;
      r_d_ack      <= w_done_d;
      if (w_latch) begin
        if (w_gnt_d_next) begin
          r_we    <= d_we;
          r_size  <= d_size;
          r_addr  <= d_addr[ADDR_W-1:0];
          r_wdata <= d_wdata;
        end else begin
          r_we    <= 1'b0;
          r_size  <= SZ_WORD;
          r_addr  <= if_addr;
          r_wdata <= '0;
        end
      end
      if ((w_state_next == DONE) && !w_gnt_d_next) r_if_rdata <= bswap32(w_rx_next);
      if (w_done_d) begin
        r_d_err   <= w_err_next;
        r_d_rdata <= (w_err_next || r_we) ? 32'h0 : rx_order(w_rx_next, r_size);
      end
      if (r_state == DONE) r_last_d <= r_gnt_d;
    end
  end

  assign cs_flash_n = r_cs_flash_n;
  assign cs_ram_n   = r_cs_ram_n;
  assign if_ack     = r_if_ack;
  assign if_rdata   = r_if_rdata;
  assign d_ack      = r_d_ack;
  assign d_rdata    = r_d_rdata;
  assign d_err      = r_d_err;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter with a behavioural SPI memory slave.
module tb_spi_mem_arbiter;

  localparam int unsigned ADDR_W = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [1:0]        d_size = 2'd0;
  logic [ADDR_W:0]   d_addr = '0;
  logic [31:0]       d_wdata = '0;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic              sclk, mosi, cs_flash_n, cs_ram_n;
  logic              miso = 1'b0;

  int errors = 0;
  int checks = 0;

  // Slave state
  logic [63:0] cap = '0;
  logic [31:0] serve = '0;
  int          nbits = 0;
  int          sclk_rises = 0;
  int          flash_low_cnt = 0;
  int          ram_low_cnt = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_low = 1'b0;
  logic [4:0]  idx;

  spi_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_flash_n(cs_flash_n), .cs_ram_n(cs_ram_n)
  );

  always #5 clk = ~clk;

  // Memory slave: captures mosi on sclk rise, presents data bits while sclk low.
  always @(posedge clk) begin
    #1;
    if ((!cs_flash_n || !cs_ram_n) && !prev_low) begin
      cap   = '0;
      nbits = 0;
    end
    if (sclk && !prev_sclk) begin
      cap = {cap[62:0], mosi};
      nbits++;
      sclk_rises++;
    end
    if (!sclk) begin
      idx  = 5'(63 - nbits);
      miso = (nbits >= 32 && nbits < 64) ? serve[idx] : 1'b0;
    end
    if (!cs_flash_n) flash_low_cnt++;
    if (!cs_ram_n) ram_low_cnt++;
    prev_sclk = sclk;
    prev_low  = !cs_flash_n || !cs_ram_n;
  end

  task automatic wait_ack(output int t_ack, output int t_cs, output logic [31:0] rd,
                          output logic er, output bit was_d);
    t_ack = 0; t_cs = 0; rd = '0; er = 1'b0; was_d = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (t_cs == 0 && (!cs_flash_n || !cs_ram_n)) t_cs = i;
      if (if_ack || d_ack) begin
        t_ack = i;
        was_d = d_ack;
        rd    = d_ack ? d_rdata : if_rdata;
        er    = d_err;
        break;
      end
    end
  endtask

  task automatic fetch_txn(input logic [ADDR_W-1:0] a, input logic [31:0] srv,
                           output int t_ack, output int t_cs, output logic [31:0] rd);
    logic er; bit wd;
    @(negedge clk);
    serve = srv; if_addr = a; if_req = 1'b1;
    wait_ack(t_ack, t_cs, rd, er, wd);
    if_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [1:0] sz, input logic [ADDR_W:0] a,
                          input logic [31:0] wd, input logic [31:0] srv,
                          output int t_ack, output int t_cs, output logic [31:0] rd, output logic er);
    bit was_d;
    @(negedge clk);
    serve = srv; d_we = we; d_size = sz; d_addr = a; d_wdata = wd; d_req = 1'b1;
    wait_ack(t_ack, t_cs, rd, er, was_d);
    d_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs_flash_n, cs_ram_n, sclk, mosi} !== 4'b1100) begin
      errors++; $display("FAIL reset_bus: got %b expected 1100", {cs_flash_n, cs_ram_n, sclk, mosi});
    end
    checks++;
    if ({if_ack, d_ack, d_err} !== 3'b000) begin
      errors++; $display("FAIL reset_ack: got %b expected 000", {if_ack, d_ack, d_err});
    end
    checks++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    int t_ack, t_cs; logic [31:0] rd;
    fetch_txn(24'h000100, 32'h78563412, t_ack, t_cs, rd);
    checks++;
    if (t_ack !== 130 || t_cs !== 1) begin
      errors++; $display("FAIL fetch_latency: got ack=%0d cs=%0d expected 130/1", t_ack, t_cs);
    end
    checks++;
    if (rd !== 32'h12345678) begin
      errors++; $display("FAIL fetch_rdata: got %h expected 12345678", rd);
    end
    checks++;
    if (cap !== 64'h03000100_00000000) begin
      errors++; $display("FAIL fetch_mosi: got %h expected 0300010000000000", cap);
    end
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b0 || if_rdata !== 32'h12345678 || cs_flash_n !== 1'b1) begin
      errors++; $display("FAIL fetch_pulse: got ack=%b rdata=%h cs=%b expected 0/12345678/1",
                         if_ack, if_rdata, cs_flash_n);
    end
  endtask

  task automatic test_back_to_back();
    int t_ack, t_cs; logic [31:0] rd; logic er; bit wd;
    logic [3:0] order;
    order = '0;
    @(negedge clk);
    serve = '0; d_we = 1'b1; d_size = 2'd2; d_addr = 25'h0_000020; if_addr = 24'h0; 
    d_req = 1'b1; if_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(t_ack, t_cs, rd, er, wd);
      order = {order[2:0], wd};
    end
    d_req = 1'b0; if_req = 1'b0;
    checks++;
    if (order !== 4'b1010) begin
      errors++; $display("FAIL arb_order: got %b expected 1010 (1=data)", order);
    end
  endtask

  task automatic test_flash_reads();
    int t_ack, t_cs; logic [31:0] rd; logic er;
    data_txn(1'b0, 2'd0, 25'h0_000040, 32'h0, 32'h5A000000, t_ack, t_cs, rd, er);
    checks++;
    if (rd !== 32'h0000005A || er !== 1'b0 || t_ack !== 82) begin
      errors++; $display("FAIL byte_read: got rd=%h err=%b ack=%0d expected 0000005a/0/82", rd, er, t_ack);
    end
    checks++;
    if (cap[39:0] !== 40'h03_000040_00) begin
      errors++; $display("FAIL byte_read_mosi: got %h expected 0300004000", cap[39:0]);
    end
    data_txn(1'b0, 2'd1, 25'h0_000200, 32'h0, 32'hBEEF0000, t_ack, t_cs, rd, er);
    checks++;
    if (rd !== 32'h0000EFBE || er !== 1'b0 || t_ack !== 98) begin
      errors++; $display("FAIL half_read: got rd=%h err=%b ack=%0d expected 0000efbe/0/98", rd, er, t_ack);
    end
    data_txn(1'b0, 2'd3, 25'h0_000300, 32'h0, 32'hDEADBEEF, t_ack, t_cs, rd, er);
    checks++;
    if (rd !== 32'hEFBEADDE || er !== 1'b0 || t_ack !== 130) begin
      errors++; $display("FAIL size3_read: got rd=%h err=%b ack=%0d expected efbeadde/0/130", rd, er, t_ack);
    end
  endtask

  task automatic test_flash_write();
    int t_ack, t_cs, rises0; logic [31:0] rd; logic er;
    rises0 = sclk_rises;
    data_txn(1'b1, 2'd2, 25'h0_000020, 32'h11223344, 32'h0, t_ack, t_cs, rd, er);
    checks++;
    if (t_ack !== 1 || er !== 1'b1 || t_cs !== 0) begin
      errors++; $display("FAIL flash_write: got ack=%0d err=%b cs=%0d expected 1/1/0", t_ack, er, t_cs);
    end
    checks++;
    if (sclk_rises !== rises0) begin
      errors++; $display("FAIL flash_write_sclk: got %0d rises expected %0d", sclk_rises, rises0);
    end
  endtask

  task automatic test_ram();
    int t_ack, t_cs, fl0, rm0; logic [31:0] rd; logic er;
    fl0 = flash_low_cnt; rm0 = ram_low_cnt;
    data_txn(1'b1, 2'd0, 25'h1_000010, 32'h123456A5, 32'h0, t_ack, t_cs, rd, er);
`ifdef SPI_RAM_EN
    checks++;
    if (t_ack !== 82 || er !== 1'b0 || cap[39:0] !== 40'h02_000010_A5) begin
      errors++; $display("FAIL ram_write: got ack=%0d err=%b mosi=%h expected 82/0/02000010a5", t_ack, er, cap[39:0]);
    end
    checks++;
    if (flash_low_cnt !== fl0 || ram_low_cnt !== rm0 + 81) begin
      errors++; $display("FAIL ram_write_cs: got flash=%0d ram=%0d expected %0d/%0d",
                         flash_low_cnt, ram_low_cnt, fl0, rm0 + 81);
    end
    data_txn(1'b0, 2'd1, 25'h1_000004, 32'h0, 32'hBEEF0000, t_ack, t_cs, rd, er);
    checks++;
    if (rd !== 32'h0000EFBE || er !== 1'b0) begin
      errors++; $display("FAIL ram_half_read: got rd=%h err=%b expected 0000efbe/0", rd, er);
    end
`else
    checks++;
    if (t_ack !== 1 || er !== 1'b1) begin
      errors++; $display("FAIL ram_write_noram: got ack=%0d err=%b expected 1/1", t_ack, er);
    end
    data_txn(1'b0, 2'd1, 25'h1_000004, 32'h0, 32'hBEEF0000, t_ack, t_cs, rd, er);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1 || t_ack !== 1) begin
      errors++; $display("FAIL ram_half_read_noram: got rd=%h err=%b ack=%0d expected 0/1/1", rd, er, t_ack);
    end
    checks++;
    if (ram_low_cnt !== rm0 || flash_low_cnt !== fl0) begin
      errors++; $display("FAIL ram_cs_noram: got ram=%0d flash=%0d expected %0d/%0d",
                         ram_low_cnt, flash_low_cnt, rm0, fl0);
    end
`endif
  endtask

  task automatic test_req_drop();
    int t_ack, t_cs; logic [31:0] rd; logic er; bit wd;
    @(negedge clk);
    serve = 32'hA1B2C3D4; if_addr = 24'h000400; if_req = 1'b1;
    repeat (10) @(negedge clk);
    if_req = 1'b0;
    wait_ack(t_ack, t_cs, rd, er, wd);
    checks++;
    if (t_ack + 10 !== 130 || rd !== 32'hD4C3B2A1 || wd !== 1'b0) begin
      errors++; $display("FAIL req_drop: got ack=%0d rd=%h expected 130/d4c3b2a1", t_ack + 10, rd);
    end
  endtask

  task automatic test_reset_mid();
    int t_ack, t_cs, acks; logic [31:0] rd;
    @(negedge clk);
    serve = 32'h0; if_addr = 24'h000100; if_req = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({cs_flash_n, cs_ram_n, sclk, if_ack} !== 4'b1100) begin
      errors++; $display("FAIL reset_mid: got %b expected 1100", {cs_flash_n, cs_ram_n, sclk, if_ack});
    end
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (if_ack || d_ack || !cs_flash_n) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", acks);
    end
    fetch_txn(24'h000ABC, 32'hCAFEF00D, t_ack, t_cs, rd);
    checks++;
    if (rd !== 32'h0DF0FECA || t_ack !== 130) begin
      errors++; $display("FAIL reset_mid_refetch: got rd=%h ack=%0d expected 0df0feca/130", rd, t_ack);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_flash_reads();
    test_flash_write();
    test_ram();
    test_req_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
